// File: rtl/lca_pipe_adder_pkg.sv
// lca_pipe_adder_pkg
// Shared constants for the pipelined lookahead-carry adder.
//   LCA_GROUP : bit width of one lookahead carry group (full_adder_Nbit_lca)
package lca_pipe_adder_pkg;

  localparam int LCA_GROUP = 4;

endpackage : lca_pipe_adder_pkg

// File: rtl/lca_pipe_adder_group.sv
// full_adder_Nbit_lca
// One 4-bit lookahead-carry group: every internal carry and the group
// carry-out are formed directly from generate/propagate terms and cin, so the
// group adds only two gate levels of carry delay regardless of its inputs.
// Ports:
//   a_n, b_n : group operands
//   cin      : carry into bit 0 of the group
//   s_n      : group sum
//   cout     : carry out of the group's top bit
module full_adder_Nbit_lca
  import lca_pipe_adder_pkg::*;
(
  input  logic [LCA_GROUP-1:0] a_n,
  input  logic [LCA_GROUP-1:0] b_n,
  input  logic                 cin,
  output logic [LCA_GROUP-1:0] s_n,
  output logic                 cout
);

  logic [LCA_GROUP-1:0] g;   // bit generates
  logic [LCA_GROUP-1:0] p;   // bit propagates
  logic [LCA_GROUP-1:0] c;   // carry into each bit

  assign g = a_n & b_n;
  assign p = a_n ^ b_n;

  // Each carry is flattened to sum-of-products; no carry feeds another.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | ((&p) & cin);

  assign s_n = p ^ c;

endmodule : full_adder_Nbit_lca

// File: rtl/lca_pipe_adder.sv
// lca_pipe_adder
// Pipelined, valid/ready flow-controlled WIDTH-bit adder. The addition is cut
// into STAGES segments of SEG bits; each stage adds one segment with cascaded
// 4-bit lookahead groups and registers the partial sum, the segment carry and
// the operand segments still to be added. Capacity is STAGES beats, bubbles
// collapse, and results leave in acceptance order.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin sampled on transfer)
//   out_valid/out_ready : result handshake (sum, cout straight from flops)
//   sum, cout           : a + b + cin modulo 2^WIDTH, and the carry out
module lca_pipe_adder
  import lca_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / LCA_GROUP;

  if ((WIDTH % (LCA_GROUP * STAGES)) != 0) begin : g_width_check
    $error("lca_pipe_adder: WIDTH must be a multiple of 4*STAGES");
  end

  logic [STAGES-1:0] v_reg;   // stage holds a beat
  logic [STAGES-1:0] adv;     // stage hands its beat downstream this cycle
  logic [STAGES-1:0] fill;    // stage captures a beat this cycle

  // Ready chain, evaluated from the output end: a stage may move when the
  // stage below is empty or is itself moving. 'room' ends as stage 0's
  // ability to take a new beat, which depends on out_ready but never on
  // in_valid.
  always_comb begin : ready_chain
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = v_reg[k] && room;
      room   = !v_reg[k] || adv[k];
    end
    in_ready = room;
  end

  always_comb begin : fill_chain
    fill    = '0;
    fill[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      fill[k] = adv[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= '0;
    end else begin
      v_reg <= fill | (v_reg & ~adv);
    end
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // Segments not yet summed when the beat enters this stage; operand
    // slices are kept right-aligned so the current segment is always [SEG-1:0].
    localparam int REM = STAGES - gi;

    logic [REM*SEG-1:0]    a_src;
    logic [REM*SEG-1:0]    b_src;
    logic                  c_src;
    logic [SEG-1:0]        s_seg;
    logic                  c_next;
    logic [(gi+1)*SEG-1:0] sum_next;
    logic [(gi+1)*SEG-1:0] sum_reg;   // finished sum segments 0..gi
    logic                  c_reg;     // carry out of segment gi

    if (gi == 0) begin : g_head
      assign a_src    = a;
      assign b_src    = b;
      assign c_src    = cin;
      assign sum_next = s_seg;
    end else begin : g_link
      assign a_src    = g_stage[gi-1].g_ops.a_reg;
      assign b_src    = g_stage[gi-1].g_ops.b_reg;
      assign c_src    = g_stage[gi-1].c_reg;
      assign sum_next = {s_seg, g_stage[gi-1].sum_reg};
    end

    for (genvar gj = 0; gj < NGRP; gj++) begin : g_grp
      logic c_in;
      logic c_out;
      if (gj == 0) begin : g_first
        assign c_in = c_src;
      end else begin : g_next
        assign c_in = g_grp[gj-1].c_out;
      end
      full_adder_Nbit_lca u_grp (
        .a_n  (a_src[gj*LCA_GROUP +: LCA_GROUP]),
        .b_n  (b_src[gj*LCA_GROUP +: LCA_GROUP]),
        .cin  (c_in),
        .s_n  (s_seg[gj*LCA_GROUP +: LCA_GROUP]),
        .cout (c_out)
      );
    end
    assign c_next = g_grp[NGRP-1].c_out;

    // Data flops only load on capture so a stalled stage holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg <= '0;
        c_reg   <= 1'b0;
      end else if (fill[gi]) begin
        sum_reg <= sum_next;
        c_reg   <= c_next;
      end
    end

    // The last stage has no operand segments left to carry forward.
    if (gi < STAGES - 1) begin : g_ops
      logic [(REM-1)*SEG-1:0] a_reg;
      logic [(REM-1)*SEG-1:0] b_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (fill[gi]) begin
          a_reg <= a_src[REM*SEG-1:SEG];
          b_reg <= b_src[REM*SEG-1:SEG];
        end
      end
    end
  end

  assign out_valid = v_reg[STAGES-1];
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].c_reg;

endmodule : lca_pipe_adder

// File: tb/tb_lca_pipe_adder.sv
// tb_lca_pipe_adder
// Self-checking bench for lca_pipe_adder (WIDTH=64, STAGES=4). A queue model
// tracks every accepted beat with its exact 65-bit arithmetic result and its
// position in the pipe; a negedge process compares out_valid, in_ready and
// the result against it every cycle. Directed sequences pin literal values,
// latency, backpressure capacity and mid-flight reset.
module tb_lca_pipe_adder;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;

  // Model: expected {cout,sum} per in-flight beat, and its stage position.
  logic [WIDTH:0] exp_q[$];
  int             pos_q[$];
  int             cyc         = 0;
  int             acc_cyc     = 0;
  bit             last_accept = 1'b0;

  lca_pipe_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [WIDTH:0] act,
                     input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural model: at each edge the oldest beat leaves if it sits at the
  // output and the consumer is ready; remaining beats each move one place
  // toward the output unless the beat ahead of them blocks; a new beat
  // enters at position 0 if the pipe is not full or is draining.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        pos_q.delete();
        last_accept = 1'b0;
      end else begin
        bit acc;
        int lim;
        cyc++;
        acc = in_valid && ((exp_q.size() < STAGES) || out_ready);
        last_accept = acc;
        if (acc) acc_cyc = cyc;
        if (exp_q.size() > 0 && pos_q[0] == STAGES - 1 && out_ready) begin
          void'(exp_q.pop_front());
          void'(pos_q.pop_front());
        end
        for (int i = 0; i < pos_q.size(); i++) begin
          lim = (i == 0) ? STAGES - 1 : pos_q[i-1] - 1;
          pos_q[i] = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
        end
        if (acc) begin
          exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
          pos_q.push_back(0);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit ev;
        ev = 1'b0;
        if (exp_q.size() > 0) ev = (pos_q[0] == STAGES - 1);
        chk("out_valid", 65'(out_valid), 65'(ev));
        chk("in_ready", 65'(in_ready),
            65'((exp_q.size() < STAGES) || out_ready));
        if (ev && out_valid) chk("result", {cout, sum}, exp_q[0]);
      end
    end
  end

  // Offer one beat from posedge+1 until accepted or the budget runs out.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic cv, input int budget, output bit ok);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = last_accept;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
  endtask

  initial begin
    bit               ok;
    bit               seen;
    logic [WIDTH-1:0] hold;
    int               k;
    int               outs;
    int               nacc;
    int               ncyc;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 65'(out_valid), 65'(0));
    chk("reset_sum", 65'(sum), 65'(0));
    chk("reset_cout", 65'(cout), 65'(0));
    chk("reset_in_ready", 65'(in_ready), 65'(1));
    rst_n = 1'b1;

    // Basic add and latency.
    send(64'h1, 64'h2, 1'b0, 10, ok);
    chk("basic_accept", 65'(ok), 65'(1));
    wait_out(10, seen);
    chk("basic_seen", 65'(seen), 65'(1));
    chk("basic_latency", 65'(cyc - acc_cyc), 65'(3));
    chk("basic_sum", {cout, sum}, 65'h0_0000_0000_0000_0003);
    $display("txn basic: sum=0x%h cout=%0d", sum, cout);
    @(posedge clk);
    #1;

    // Carry ripples across every stage.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 10, ok);
    wait_out(10, seen);
    chk("ripple_seen", 65'(seen), 65'(1));
    chk("ripple_sum", {cout, sum}, 65'h1_0000_0000_0000_0000);
    $display("txn ripple: sum=0x%h cout=%0d", sum, cout);
    @(posedge clk);
    #1;

    // Overflow wraps, carry on cout only.
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 10, ok);
    wait_out(10, seen);
    chk("overflow_seen", 65'(seen), 65'(1));
    chk("overflow_sum", {cout, sum}, 65'h1_0000_0000_0000_0000);
    $display("txn overflow: sum=0x%h cout=%0d", sum, cout);
    @(posedge clk);
    #1;

    // Backpressure: 6 beats offered with the consumer stalled.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (k < 6);
      a = 64'h0123_4567_89AB_CDEF * 64'(k + 1);
      b = 64'hF0F0_F0F0_F0F0_F0F0 + 64'(k);
      cin = k[0];
      @(posedge clk);
      #1;
      if (last_accept) k++;
    end
    chk("bp_accepted", 65'(k), 65'(4));
    chk("bp_in_ready", 65'(in_ready), 65'(0));
    @(negedge clk);
    hold = sum;
    repeat (3) @(negedge clk);
    chk("bp_sum_stable", 65'(sum), 65'(hold));
    chk("bp_out_valid", 65'(out_valid), 65'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    outs = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (k < 6);
      a = 64'h0123_4567_89AB_CDEF * 64'(k + 1);
      b = 64'hF0F0_F0F0_F0F0_F0F0 + 64'(k);
      cin = k[0];
      @(negedge clk);
      if (out_valid) begin
        outs++;
        $display("txn backpressure out %0d: sum=0x%h cout=%0d", c, sum, cout);
      end
      @(posedge clk);
      #1;
      if (last_accept) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 65'(k), 65'(6));
    chk("bp_back_to_back", 65'(outs), 65'(6));

    // Random valid/ready stress; every output checked by the compare process.
    nacc = 0;
    ncyc = 0;
    while (nacc < 10000 && ncyc < 60000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: begin a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; end
        1: begin a = {$urandom(), $urandom()}; b = ~a; end
        2: begin a = '1; b = 64'($urandom_range(0, 3)); end
        default: begin a = {$urandom(), $urandom()}; b = a; end
      endcase
      cin = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      ncyc++;
      if (last_accept) nacc++;
    end
    in_valid = 1'b0;
    chk("random_beats", 65'(nacc), 65'(10000));
    $display("txn random: %0d beats in %0d cycles", nacc, ncyc);
    out_ready = 1'b1;
    repeat (STAGES + 2) @(posedge clk);
    #1;
    chk("drain_out_valid", 65'(out_valid), 65'(0));

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(64'(100 + i), 64'(7 * i), 1'b0, 10, ok);
      chk("rst_fill_accept", 65'(ok), 65'(1));
    end
    @(posedge clk);
    #1;
    chk("rst_pre_out_valid", 65'(out_valid), 65'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", 65'(out_valid), 65'(0));
    chk("rst_async_sum", 65'(sum), 65'(0));
    chk("rst_async_cout", 65'(cout), 65'(0));
    chk("rst_async_in_ready", 65'(in_ready), 65'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_ghost", 65'(out_valid), 65'(0));
    send(64'h5, 64'h7, 1'b1, 10, ok);
    wait_out(10, seen);
    chk("post_rst_seen", 65'(seen), 65'(1));
    chk("post_rst_sum", {cout, sum}, 65'h0_0000_0000_0000_000D);
    $display("txn post-reset: sum=0x%h cout=%0d", sum, cout);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lca_pipe_adder
